// File: rtl/gpu_pkg.sv
// gpu_pkg: shared widths, coordinate/product types and setup FSM encoding for the triangle setup unit.
package gpu_pkg;
    localparam int DEF_COORD_WIDTH = 16;
    localparam int DEF_COLOR_WIDTH = 16;
    typedef logic signed [DEF_COORD_WIDTH-1:0]   coord_t;
    typedef logic signed [2*DEF_COORD_WIDTH-1:0] mul_res_t;
    typedef enum logic [1:0] {IDLE, CALC, SUM, OUT} setup_state_e;
    typedef enum logic {MAC_LOAD, MAC_SUB} mac_op_e;
endpackage

// File: rtl/tri_setup_mac.sv
// tri_setup_mac: shared signed W x W multiplier that either loads the product or subtracts it from an accumulator.
module tri_setup_mac import gpu_pkg::*; #(
    parameter int W = DEF_COORD_WIDTH
) (
    input  logic signed [W-1:0]   mul_a_i,
    input  logic signed [W-1:0]   mul_b_i,
    input  logic signed [2*W-1:0] acc_i,
    input  mac_op_e               op_i,
    output logic signed [2*W-1:0] res_o
);
    logic signed [2*W-1:0] prod;
    assign prod  = (2*W)'(mul_a_i) * (2*W)'(mul_b_i);
    assign res_o = op_i == MAC_SUB ? acc_i - prod : prod;
endmodule

// File: rtl/tri_setup.sv
// tri_setup: turns three screen-space vertices into edge-function coefficients {a_i, b_i, c_i},
// sharing one multiplier over six cycles per triangle.
module tri_setup import gpu_pkg::*; #(
    parameter int COORD_WIDTH = DEF_COORD_WIDTH,
    parameter int COLOR_WIDTH = DEF_COLOR_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [COORD_WIDTH-1:0]   vx [3],
    input  logic signed [COORD_WIDTH-1:0]   vy [3],
    input  logic [COLOR_WIDTH-1:0]          color_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [COORD_WIDTH-1:0]   bound_coefs [3][2],
    output logic signed [2*COORD_WIDTH-1:0] bound_const [3],
    output logic [COLOR_WIDTH-1:0]          color_out,
    output logic                            degenerate
);
    localparam int W = COORD_WIDTH;
    setup_state_e          state_q, state_d;
    logic [2:0]            step_q, step_d;
    logic signed [W-1:0]   vx_q [3];
    logic signed [W-1:0]   vy_q [3];
    logic signed [W-1:0]   coef_q [3][2];
    logic signed [2*W-1:0] const_q [3];
    logic [COLOR_WIDTH-1:0] color_q;
    logic                  degen_q;
    logic                  accept;
    logic [1:0]            e, j;
    logic signed [W-1:0]   mul_a, mul_b;
    logic signed [2*W-1:0] mac_res, csum;
    mac_op_e               op;

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == OUT;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = CALC;
                step_d  = '0;
            end
            CALC: begin
                step_d  = step_q + 3'd1;
                state_d = step_q == 3'd5 ? SUM : CALC;
            end
            SUM:     state_d = OUT;
            default: state_d = out_ready ? IDLE : OUT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Step k works on edge k/2: even steps load vx[e]*vy[j], odd steps subtract vx[j]*vy[e].
    assign e     = step_q[2:1];
    assign j     = e == 2'd2 ? 2'd0 : e + 2'd1;
    assign op    = step_q[0] ? MAC_SUB : MAC_LOAD;
    assign mul_a = step_q[0] ? vx_q[j] : vx_q[e];
    assign mul_b = step_q[0] ? vy_q[e] : vy_q[j];
    assign csum  = const_q[0] + const_q[1] + const_q[2];

    tri_setup_mac #(.W(W)) u_mac (
        .mul_a_i (mul_a),
        .mul_b_i (mul_b),
        .acc_i   (const_q[e]),
        .op_i    (op),
        .res_o   (mac_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                vx_q[i]      <= '0;
                vy_q[i]      <= '0;
                coef_q[i][0] <= '0;
                coef_q[i][1] <= '0;
                const_q[i]   <= '0;
            end
            color_q <= '0;
            degen_q <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    vx_q[i]      <= vx[i];
                    vy_q[i]      <= vy[i];
                    coef_q[i][0] <= vy[i] - vy[(i + 1) % 3];
                    coef_q[i][1] <= vx[(i + 1) % 3] - vx[i];
                end
                color_q <= color_in;
            end
            if (state_q == CALC)
                const_q[e] <= mac_res;
            if (state_q == SUM)
                degen_q <= csum == '0;
        end
    end

    assign bound_coefs = coef_q;
    assign bound_const = const_q;
    assign color_out   = color_q;
    assign degenerate  = degen_q;
endmodule

// File: tb/tb_tri_setup.sv
// tb_tri_setup: directed vector table plus backpressure and mid-calculation reset sequences for tri_setup.
module tb_tri_setup;
    localparam int W  = 16;
    localparam int CW = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  out_ready = 1'b1;
    logic                  in_ready, out_valid, degenerate;
    logic signed [W-1:0]   vx [3];
    logic signed [W-1:0]   vy [3];
    logic [CW-1:0]         color_in = '0;
    logic [CW-1:0]         color_out;
    logic signed [W-1:0]   bound_coefs [3][2];
    logic signed [2*W-1:0] bound_const [3];

    int checks = 0;
    int failures = 0;

    typedef struct {
        int     x [3];
        int     y [3];
        int     a [3];
        int     b [3];
        longint c [3];
        bit     deg;
    } vec_t;
    vec_t vt [5];

    always #5 clk = ~clk;

    tri_setup dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .vx          (vx),
        .vy          (vy),
        .color_in    (color_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .bound_coefs (bound_coefs),
        .bound_const (bound_const),
        .color_out   (color_out),
        .degenerate  (degenerate)
    );

    task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic check_outputs(input int n);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("v%0d_a%0d", n, i), bound_coefs[i][0], vt[n].a[i]);
            chk($sformatf("v%0d_b%0d", n, i), bound_coefs[i][1], vt[n].b[i]);
            chk($sformatf("v%0d_c%0d", n, i), bound_const[i], vt[n].c[i]);
        end
        chk($sformatf("v%0d_degenerate", n), degenerate, vt[n].deg);
        chk($sformatf("v%0d_color", n), color_out, 64'hA000 + n);
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_a%0d", tag, i), bound_coefs[i][0], 0);
            chk($sformatf("%s_b%0d", tag, i), bound_coefs[i][1], 0);
            chk($sformatf("%s_c%0d", tag, i), bound_const[i], 0);
        end
        chk({tag, "_color"}, color_out, 0);
        chk({tag, "_degenerate"}, degenerate, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
    endtask

    task automatic scramble();
        for (int i = 0; i < 3; i++) begin
            vx[i] = W'($urandom);
            vy[i] = W'($urandom);
        end
        color_in = CW'($urandom);
    endtask

    // Presents vector n for exactly one accepting edge, then corrupts the inputs.
    task automatic send(input int n);
        @(negedge clk);
        chk($sformatf("v%0d_in_ready", n), in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            vx[i] = W'(vt[n].x[i]);
            vy[i] = W'(vt[n].y[i]);
        end
        color_in = CW'(16'hA000 + n);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_out(input int n);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk($sformatf("v%0d_latency", n), cyc, 7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{x: '{0, 10, 0}, y: '{0, 0, 10}, a: '{0, -10, 10}, b: '{10, -10, 0},
                  c: '{0, 100, 0}, deg: 1'b0};
        vt[1] = '{x: '{0, 5, 10}, y: '{0, 5, 10}, a: '{-5, -5, 10}, b: '{5, 5, -10},
                  c: '{0, 0, 0}, deg: 1'b1};
        vt[2] = '{x: '{-3, 4, 0}, y: '{2, -1, 5}, a: '{3, -6, 3}, b: '{7, -4, -3},
                  c: '{-5, 20, 15}, deg: 1'b0};
        vt[3] = '{x: '{-32768, 32767, 0}, y: '{0, 0, 0}, a: '{0, 0, 0}, b: '{-1, -32767, -32768},
                  c: '{0, 0, 0}, deg: 1'b1};
        vt[4] = '{x: '{-32768, 0, 32767}, y: '{0, -32768, 32767}, a: '{-32768, 1, 32767},
                  b: '{-32768, 32767, 1}, c: '{1073741824, 1073709056, 1073709056}, deg: 1'b0};
        scramble();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 5; n++) begin
            send(n);
            wait_out(n);
            check_outputs(n);
            if (n == 0)
                for (int i = 0; i < 3; i++)
                    chk($sformatf("plug11_e%0d", i),
                        64'(bound_coefs[i][0]) + 64'(bound_coefs[i][1]) + 64'(bound_const[i]),
                        i == 1 ? 80 : 10);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_handshake_valid", n), out_valid, 0);
            chk($sformatf("v%0d_handshake_ready", n), in_ready, 1);
            chk($sformatf("v%0d_held_c1", n), bound_const[1], vt[n].c[1]);
        end

        out_ready = 1'b0;
        send(2);
        wait_out(2);
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1;
            scramble();
            @(posedge clk);
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            check_outputs(2);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("bp_idle_after", in_ready, 1);
        check_outputs(2);

        send(3);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_in_ready", in_ready, 1);
        check_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_ready", in_ready, 1);
        chk("post_reset_valid", out_valid, 0);
        send(0);
        wait_out(0);
        check_outputs(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
